// File: rtl/timer_responder.sv
// timer_responder: register-mapped down-counting timer with expiry flag, auto-reload and level irq.
// Define TIMER_PRESCALER_EN to build the PSC register and prescaler counter; otherwise it ticks every enabled cycle.
module timer_responder #(
  parameter int PSC_W = 16,
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] addr,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [9:0] A_CTRL   = 10'd0;
  localparam logic [9:0] A_LOAD   = 10'd1;
  localparam logic [9:0] A_COUNT  = 10'd2;
  localparam logic [9:0] A_STATUS = 10'd3;
  localparam logic [9:0] A_PSC    = 10'd4;

  logic [9:0]       word;
  logic             en_reg, en_next, ar_reg, ar_next, ien_reg, ien_next, exp_reg, exp_next;
  logic [CNT_W-1:0] load_reg, load_next, count_reg, count_next;
  logic             wr_ctrl, wr_load, wr_status;
  logic             tick, tick_eff, expire;
  logic [31:0]      psc_rd;
  logic             unused_addr_bits;

  assign word             = addr[11:2];
  assign unused_addr_bits = ^addr[1:0];
  assign wr_ctrl          = wen && (word == A_CTRL);
  assign wr_load          = wen && (word == A_LOAD);
  assign wr_status        = wen && (word == A_STATUS);

`ifdef TIMER_PRESCALER_EN
  logic [PSC_W-1:0] psc_reg, psc_next, psc_cnt_reg, psc_cnt_next;
  logic             wr_psc;

  assign wr_psc = wen && (word == A_PSC);
  assign tick   = en_reg && (psc_cnt_reg == psc_reg);
  assign psc_rd = 32'(psc_reg);

  always_comb begin
    psc_next     = wr_psc ? wdata[PSC_W-1:0] : psc_reg;
    psc_cnt_next = psc_cnt_reg;
    if (wr_load || tick)
      psc_cnt_next = '0;
    else if (en_reg)
      psc_cnt_next = psc_cnt_reg + PSC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      psc_reg     <= '0;
      psc_cnt_reg <= '0;
    end else begin
      psc_reg     <= psc_next;
      psc_cnt_reg <= psc_cnt_next;
    end
  end
`else
  assign tick   = en_reg;
  assign psc_rd = '0;
`endif

  // A LOAD write restarts the count, so a tick landing on the same edge is dropped.
  assign tick_eff = tick && !wr_load;
  assign expire   = tick_eff && (count_reg == '0);

  always_comb begin
    en_next   = en_reg;
    ar_next   = ar_reg;
    ien_next  = ien_reg;
    load_next = load_reg;
    count_next = count_reg;
    exp_next  = exp_reg;

    if (expire && !ar_reg)
      en_next = 1'b0;
    if (wr_ctrl) begin
      en_next  = wdata[0];
      ar_next  = wdata[1];
      ien_next = wdata[2];
    end

    if (wr_load) begin
      load_next  = wdata[CNT_W-1:0];
      count_next = wdata[CNT_W-1:0];
    end else if (tick_eff) begin
      if (count_reg != '0)
        count_next = count_reg - CNT_W'(1);
      else if (ar_reg)
        count_next = load_reg;
    end

    // Clear first so a simultaneous expiry keeps the flag set.
    if (wr_status && wdata[0])
      exp_next = 1'b0;
    if (expire)
      exp_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      en_reg    <= 1'b0;
      ar_reg    <= 1'b0;
      ien_reg   <= 1'b0;
      exp_reg   <= 1'b0;
      load_reg  <= '0;
      count_reg <= '0;
    end else begin
      en_reg    <= en_next;
      ar_reg    <= ar_next;
      ien_reg   <= ien_next;
      exp_reg   <= exp_next;
      load_reg  <= load_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    rdata = '0;
    case (word)
      A_CTRL:   rdata = {29'd0, ien_reg, ar_reg, en_reg};
      A_LOAD:   rdata = 32'(load_reg);
      A_COUNT:  rdata = 32'(count_reg);
      A_STATUS: rdata = {31'd0, exp_reg};
      A_PSC:    rdata = psc_rd;
      default:  rdata = '0;
    endcase
  end

  assign irq = exp_reg & ien_reg;

endmodule
